// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Covers the frame state machine and the word assembly parameters.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         WORD_BYTES    = 4;
    localparam int         CNT_W         = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in from the UART receiver and the write port out to instruction memory.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;

    modport master (input rx_valid, rx_data, output mem_we, mem_addr, mem_wd);
    modport slave  (output rx_valid, rx_data, input mem_we, mem_addr, mem_wd);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into words and keeps the running XOR checksum.
module loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    input  logic                    clear,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    word_valid,
    output logic [7:0]              xor_sum
);
    localparam int IW = $clog2(WORD_BYTES);
    localparam int SW = 8 * (WORD_BYTES - 1);

    logic [IW-1:0] byte_idx_q, byte_idx_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [7:0]    xor_q, xor_d;

    // The final byte completes the word directly, so no extra cycle is spent buffering it.
    assign word_valid = byte_valid && !clear && (byte_idx_q == IW'(WORD_BYTES - 1));
    assign word       = {byte_data, shift_q};
    assign xor_sum    = xor_q;

    generate
        for (genvar gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
            assign shift_d[8*gi +: 8] = (byte_valid && !clear && byte_idx_q == IW'(gi))
                                        ? byte_data : shift_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_idx_d = byte_idx_q;
        xor_d      = xor_q;
        if (clear) begin
            byte_idx_d = '0;
            xor_d      = '0;
        end else if (byte_valid) begin
            byte_idx_d = byte_idx_q + 1'b1;
            xor_d      = xor_q ^ byte_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
            shift_q    <= '0;
            xor_q      <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            xor_q      <= xor_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame parser that writes a UART-delivered program image into instruction memory
// and holds the CPU in reset while loading or after a failed load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH          = 101,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.master bus,
    output logic          cpu_rst_n,
    output logic          load_busy,
    output logic          load_done,
    output logic          load_error,
    output logic [15:0]   words_loaded
);
    localparam int              TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT_CYCLES - 1);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, word_idx_q, word_idx_d, cnt_full;
    logic [TW-1:0]    timer_q, timer_d;
    logic             mem_we_q, mem_we_d, cpu_rst_n_q, cpu_rst_n_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wd_q, mem_wd_d;
    logic             load_busy_q, load_busy_d, load_done_q, load_done_d;
    logic             load_error_q, load_error_d;
    logic [15:0]      words_loaded_q, words_loaded_d;
    logic             start, in_frame, asm_valid, word_valid;
    logic [31:0]      word;
    logic [7:0]       xor_sum;

    assign in_frame  = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                       (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign start     = bus.rx_valid && (bus.rx_data == SYNC_BYTE) && !in_frame;
    assign asm_valid = bus.rx_valid && (state_q == ST_DATA);
    assign cnt_full  = {bus.rx_data, cnt_q[7:0]};

    loader_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (asm_valid),
        .byte_data  (bus.rx_data),
        .clear      (start),
        .word       (word),
        .word_valid (word_valid),
        .xor_sum    (xor_sum)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        word_idx_d     = word_idx_q;
        timer_d        = timer_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wd_d       = mem_wd_q;
        cpu_rst_n_d    = cpu_rst_n_q;
        load_busy_d    = load_busy_q;
        load_done_d    = load_done_q;
        load_error_d   = load_error_q;
        words_loaded_d = mem_we_q ? words_loaded_q + 16'd1 : words_loaded_q;

        case (state_q)
            ST_CNT_LO: if (bus.rx_valid) begin
                cnt_d[7:0] = bus.rx_data;
                state_d    = ST_CNT_HI;
            end
            ST_CNT_HI: if (bus.rx_valid) begin
                cnt_d      = cnt_full;
                word_idx_d = '0;
                if (cnt_full > CNT_W'(DEPTH)) begin
                    state_d      = ST_ERROR;
                    load_error_d = 1'b1;
                    load_busy_d  = 1'b0;
                end else if (cnt_full == '0) begin
                    state_d = ST_CHK;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (word_valid) begin
                mem_we_d   = 1'b1;
                mem_addr_d = 32'({word_idx_q, 2'b00});
                mem_wd_d   = word;
                word_idx_d = word_idx_q + 1'b1;
                if (word_idx_q + 1'b1 == cnt_q) state_d = ST_CHK;
            end
            ST_CHK: if (bus.rx_valid) begin
                load_busy_d = 1'b0;
                if (bus.rx_data == xor_sum) begin
                    state_d     = ST_DONE;
                    load_done_d = 1'b1;
                    cpu_rst_n_d = 1'b1;
                end else begin
                    state_d      = ST_ERROR;
                    load_error_d = 1'b1;
                end
            end
            default: if (start) begin
                state_d        = ST_CNT_LO;
                load_done_d    = 1'b0;
                load_error_d   = 1'b0;
                words_loaded_d = '0;
                load_busy_d    = 1'b1;
                cpu_rst_n_d    = 1'b0;
                timer_d        = '0;
            end
        endcase

        // Inter-byte watchdog; a received byte always restarts it.
        if (in_frame) begin
            if (bus.rx_valid) begin
                timer_d = '0;
            end else if (timer_q == TMAX) begin
                state_d      = ST_ERROR;
                load_error_d = 1'b1;
                load_busy_d  = 1'b0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            word_idx_q     <= '0;
            timer_q        <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wd_q       <= '0;
            cpu_rst_n_q    <= 1'b1;
            load_busy_q    <= 1'b0;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            word_idx_q     <= word_idx_d;
            timer_q        <= timer_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wd_q       <= mem_wd_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            load_busy_q    <= load_busy_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign load_busy    = load_busy_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream from a UART receiver.
- Assembles the bytes into 32-bit little-endian words and writes them into a writable instruction memory at word-aligned byte addresses. The CPU fetch port reads them back through a[31:2].
- Holds the CPU in reset while a load is in progress and after a failed load.

Parameters:
- DEPTH, 101, number of 32-bit words in instruction memory; a load with a larger count is rejected.
- SYNC_BYTE, 8'hA5, byte that starts a load frame.
- TIMEOUT_CYCLES, 1_000_000, maximum clk cycles allowed between consecutive bytes inside a frame.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- mem_we  out  1  instruction memory write enable, one-cycle pulse
- mem_addr  out  32  byte address of the write, bits [1:0] always 0
- mem_wd  out  32  write data
- cpu_rst_n  out  1  active-low CPU reset
- load_busy  out  1  frame in progress
- load_done  out  1  sticky, last frame completed with a good checksum
- load_error  out  1  sticky, last frame failed
- words_loaded  out  16  words written in the current or last frame

Behaviour:
- Reset values:
  - state IDLE
  - mem_we=0, mem_addr=0, mem_wd=0
  - cpu_rst_n=1, so the CPU runs the preloaded image
  - load_busy=0, load_done=0, load_error=0, words_loaded=0
- Frame format: SYNC_BYTE, CNT_LO, CNT_HI, then CNT×4 data bytes (LSB first per word), then CHK.
  - CHK is the XOR of all data bytes.
  - When CNT=0 there are no data bytes and CHK must be 8'h00.
- States: IDLE, CNT_LO, CNT_HI, DATA, CHK, DONE, ERROR.
- IDLE/DONE/ERROR:
  - rx_valid with rx_data==SYNC_BYTE → CNT_LO.
  - In the same edge: clear load_done, load_error, words_loaded and the checksum; set load_busy=1 and cpu_rst_n=0.
  - Any other byte is ignored.
- CNT_LO: latch low byte → CNT_HI.
- CNT_HI: latch high byte.
  - Count > DEPTH → ERROR.
  - Count == 0 → CHK.
  - Otherwise → DATA with byte index 0 and word index 0.
- DATA:
  - Each byte is shifted into the word buffer at bit position 8×byte_idx and XORed into the checksum.
  - On the 4th byte, accepted at edge N: mem_we=1 during cycle N+1, with mem_addr = word_idx<<2 and mem_wd = the assembled word.
  - words_loaded increments at edge N+1. mem_we is low again at N+2.
  - After the last word → CHK.
- Back-to-back rx_valid on every cycle must be accepted with no byte lost. A write pulse and the next byte capture may coincide.
- CHK:
  - Byte equals the running XOR → DONE: load_done=1, load_busy=0, cpu_rst_n=1 on the same edge.
  - Mismatch → ERROR.
- ERROR: load_error=1, load_busy=0, cpu_rst_n stays 0. Memory already written is not rolled back.
- Timeout:
  - In CNT_LO, CNT_HI, DATA and CHK, a cycle counter is cleared on every rx_valid.
  - When it reaches TIMEOUT_CYCLES → ERROR.
- SYNC_BYTE received mid-frame is data, not a restart.
- rst_n asserted mid-frame: immediate return to reset values. cpu_rst_n releases to 1; the partially written image is left in memory.
- mem_addr and mem_wd hold their last values between write pulses.

Decomposition:
- imem_loader_pkg:
  - state enum loader_state_t
  - SYNC_BYTE default
  - localparams WORD_BYTES=4 and CNT_W=16
- One sub-module, loader_word_assembler:
  - Inputs: byte strobe, byte, clear.
  - Outputs: word, word_valid pulse, running XOR.
  - Owns byte_idx and the shift register.

Test Plan:
1. Reset mid-operation:
   - Stimulus: assert rst_n low with cpu_rst_n=0 during DATA.
   - Required: all outputs return to reset values asynchronously; a fresh frame A5 01 00 11 22 33 44 44 then loads mem[0]=32'h44332211.
2. Two-word frame, back-to-back bytes:
   - Stimulus: A5 02 00 EF BE AD DE 78 56 34 12 then CHK=0x00^(EF^BE^AD^DE^78^56^34^12).
   - Required: writes (0x0,DEADBEEF) and (0x4,12345678), each mem_we exactly 1 cycle; load_done=1, cpu_rst_n=1, words_loaded=2.
3. Bad checksum:
   - Stimulus: the frame of scenario 2 with the CHK byte XOR 0x01.
   - Required: both words still written; load_error=1, load_done=0, cpu_rst_n stays 0.
4. Oversize count:
   - Stimulus: A5 66 00 (102 > DEPTH).
   - Required: ERROR after CNT_HI, no mem_we ever asserted.
5. Zero count and spaced bytes:
   - Stimulus: A5 00 00 00 → DONE with words_loaded=0. Then, with TIMEOUT_CYCLES=16: A5 01 followed by 16 idle cycles.
   - Required: load_error=1 exactly at the 16th idle cycle.
6. Noise and in-frame sync:
   - Stimulus: 00 FF in IDLE, then A5 01 00 A5 A5 A5 A5 00.
   - Required: noise ignored; mem[0]=32'hA5A5A5A5; load_done=1.
